// File: rtl/vrf_masked_sb.sv
// Vector register file with per-lane write mask, pending scoreboard and a
// one-register-per-cycle clear sweep.
module vrf_masked_sb #(
    parameter int NUM_VREGS = 4,
    parameter int LANES     = 4,
    parameter int LANE_W    = 8,
    parameter int BYPASS    = 1,
    localparam int AW       = $clog2(NUM_VREGS),
    localparam int DW       = LANES * LANE_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [AW-1:0]        vreg1,
    input  logic [AW-1:0]        vreg2,
    output logic [DW-1:0]        vdata1,
    output logic [DW-1:0]        vdata2,
    output logic                 vpend1,
    output logic                 vpend2,
    input  logic [AW-1:0]        vregw,
    input  logic [DW-1:0]        vdataw,
    input  logic [LANES-1:0]     vmaskw,
    input  logic                 VRFWrite,
    input  logic [AW-1:0]        vregp,
    input  logic                 set_pend,
    input  logic                 clear_req,
    output logic                 busy,
    output logic [NUM_VREGS-1:0] pend_vec
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [AW-1:0]        cnt_reg, cnt_next;
    logic [DW-1:0]        mem_reg  [NUM_VREGS];
    logic [DW-1:0]        mem_next [NUM_VREGS];
    logic [NUM_VREGS-1:0] pend_reg, pend_next;
    logic [DW-1:0]        wmask_bits;
    logic [DW-1:0]        merged_w1, merged_w2;
    logic                 wr_act, set_act;

    assign busy    = (state_reg == ST_CLEAR);
    assign wr_act  = VRFWrite && !busy;
    assign set_act = set_pend && !busy;

    // Expand the lane mask to a bit mask once; shared by write and bypass paths.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_mask
            assign wmask_bits[gi*LANE_W +: LANE_W] = {LANE_W{vmaskw[gi]}};
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_VREGS; gi++) begin : g_reg
            logic wr_hit, clr_hit, set_hit;
            assign wr_hit  = wr_act && (vregw == AW'(gi));
            assign set_hit = set_act && (vregp == AW'(gi));
            assign clr_hit = busy && (cnt_reg == AW'(gi));

            assign mem_next[gi] = clr_hit ? '0 :
                                  wr_hit  ? ((mem_reg[gi] & ~wmask_bits) | (vdataw & wmask_bits)) :
                                            mem_reg[gi];
            // A new producer issued on the same edge as the old one's write keeps the bit set.
            assign pend_next[gi] = clr_hit ? 1'b0 :
                                   set_hit ? 1'b1 :
                                   wr_hit  ? 1'b0 :
                                             pend_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            pend_reg  <= '0;
            for (int i = 0; i < NUM_VREGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            for (int i = 0; i < NUM_VREGS; i++) begin
                mem_reg[i] <= mem_next[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clear_req) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == AW'(NUM_VREGS - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign merged_w1 = (mem_reg[vreg1] & ~wmask_bits) | (vdataw & wmask_bits);
    assign merged_w2 = (mem_reg[vreg2] & ~wmask_bits) | (vdataw & wmask_bits);

    assign vdata1   = ((BYPASS != 0) && wr_act && (vregw == vreg1)) ? merged_w1 : mem_reg[vreg1];
    assign vdata2   = ((BYPASS != 0) && wr_act && (vregw == vreg2)) ? merged_w2 : mem_reg[vreg2];
    assign vpend1   = pend_reg[vreg1];
    assign vpend2   = pend_reg[vreg2];
    assign pend_vec = pend_reg;

endmodule

// File: tb/tb_vrf_masked_sb.sv
// Directed bench for vrf_masked_sb: default instance plus an 8x2x16 no-bypass instance.
module tb_vrf_masked_sb;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  vreg1 = '0, vreg2 = '0, vregw = '0, vregp = '0;
    logic [31:0] vdata1, vdata2, vdataw = '0;
    logic [3:0]  vmaskw = '0;
    logic        vpend1, vpend2, VRFWrite = 1'b0, set_pend = 1'b0, clear_req = 1'b0, busy;
    logic [3:0]  pend_vec;

    logic [2:0]  p_vreg1 = '0, p_vreg2 = '0, p_vregw = '0, p_vregp = '0;
    logic [31:0] p_vdata1, p_vdata2, p_vdataw = '0;
    logic [1:0]  p_vmaskw = '0;
    logic        p_vpend1, p_vpend2, p_VRFWrite = 1'b0, p_busy;
    logic [7:0]  p_pend_vec;

    int err_cnt = 0;
    int chk_cnt = 0;
    int busy_hi = 0;

    always #5 clock = ~clock;

    vrf_masked_sb u_dut (
        .clock(clock), .reset(reset),
        .vreg1(vreg1), .vreg2(vreg2), .vdata1(vdata1), .vdata2(vdata2),
        .vpend1(vpend1), .vpend2(vpend2),
        .vregw(vregw), .vdataw(vdataw), .vmaskw(vmaskw), .VRFWrite(VRFWrite),
        .vregp(vregp), .set_pend(set_pend), .clear_req(clear_req),
        .busy(busy), .pend_vec(pend_vec)
    );

    vrf_masked_sb #(.NUM_VREGS(8), .LANES(2), .LANE_W(16), .BYPASS(0)) u_dut_p (
        .clock(clock), .reset(reset),
        .vreg1(p_vreg1), .vreg2(p_vreg2), .vdata1(p_vdata1), .vdata2(p_vdata2),
        .vpend1(p_vpend1), .vpend2(p_vpend2),
        .vregw(p_vregw), .vdataw(p_vdataw), .vmaskw(p_vmaskw), .VRFWrite(p_VRFWrite),
        .vregp(3'd0), .set_pend(1'b0), .clear_req(1'b0),
        .busy(p_busy), .pend_vec(p_pend_vec)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] m);
        vregw = r; vdataw = d; vmaskw = m; VRFWrite = 1'b1;
        tick();
        VRFWrite = 1'b0;
    endtask

    initial begin
        // Reset state
        vreg1 = 2'd2; vreg2 = 2'd3;
        #2;
        check_val("rst_vdata1", vdata1, 0);
        check_val("rst_vpend1", vpend1, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_pend_vec", pend_vec, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // 1: masked write with bypass
        vregw = 2'd2; vdataw = 32'hAABBCCDD; vmaskw = 4'b0101; VRFWrite = 1'b1; vreg1 = 2'd2;
        #1;
        check_val("t1_bypass", vdata1, 32'h00BB00DD);
        tick();
        VRFWrite = 1'b0;
        #1;
        check_val("t1_stored", vdata1, 32'h00BB00DD);

        // 2: pending scoreboard
        vregp = 2'd1; set_pend = 1'b1; vreg2 = 2'd1;
        tick();
        set_pend = 1'b0;
        check_val("t2_vpend2_set", vpend2, 1);
        wr(2'd1, 32'hFFFFFFFF, 4'b0000);
        check_val("t2_vpend2_clr", vpend2, 0);
        check_val("t2_mask0_data", vdata2, 0);
        vregp = 2'd3; set_pend = 1'b1;
        wr(2'd3, 32'h11223344, 4'b1111);
        set_pend = 1'b0;
        check_val("t2_same_edge_pend", pend_vec, 4'b1000);
        vreg2 = 2'd3;
        #1;
        check_val("t2_reg3_data", vdata2, 32'h11223344);
        vregp = 2'd0; set_pend = 1'b1;
        wr(2'd3, 32'h0, 4'b0000);
        set_pend = 1'b0;
        check_val("t2_diff_regs_pend", pend_vec, 4'b0001);

        // 3: clear sweep
        wr(2'd0, 32'hFFFFFFFF, 4'b1111);
        wr(2'd1, 32'hFFFFFFFF, 4'b1111);
        wr(2'd2, 32'hFFFFFFFF, 4'b1111);
        vregp = 2'd2; set_pend = 1'b1;
        wr(2'd3, 32'hFFFFFFFF, 4'b1111);
        set_pend = 1'b0;
        check_val("t3_pend_before", pend_vec, 4'b0100);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check_val("t3_busy_rise", busy, 1);
        // Write and set_pend on reg 0 while busy must be dropped and not bypassed
        vregw = 2'd0; vdataw = 32'h12345678; vmaskw = 4'b1111; VRFWrite = 1'b1;
        vregp = 2'd0; set_pend = 1'b1; vreg1 = 2'd0;
        #1;
        check_val("t3_no_bypass_busy", vdata1, 32'hFFFFFFFF);
        for (int k = 1; k <= 4; k++) begin
            tick();
            vreg1 = 2'(k - 1);
            vreg2 = 2'(k);
            #1;
            check_val($sformatf("t3_busy_%0d", k), busy, (k < 4) ? 1 : 0);
            check_val($sformatf("t3_cleared_%0d", k - 1), vdata1, 0);
            if (k < 4) check_val($sformatf("t3_intact_%0d", k), vdata2, 32'hFFFFFFFF);
        end
        VRFWrite = 1'b0; set_pend = 1'b0;
        vreg1 = 2'd0;
        #1;
        check_val("t3_dropped_write", vdata1, 0);
        check_val("t3_pend_after", pend_vec, 0);

        // 4: async reset mid-sweep
        vregp = 2'd3; set_pend = 1'b1;
        wr(2'd3, 32'hCAFEBABE, 4'b1111);
        set_pend = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        vreg1 = 2'd3;
        #1;
        check_val("t4_pre_reset_data", vdata1, 32'hCAFEBABE);
        check_val("t4_pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        check_val("t4_busy", busy, 0);
        check_val("t4_vdata1", vdata1, 0);
        check_val("t4_pend_vec", pend_vec, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check_val("t4_idle_after", busy, 0);

        // 5: 8x2x16 instance without bypass
        p_vregw = 3'd7; p_vdataw = 32'h1234ABCD; p_vmaskw = 2'b10; p_VRFWrite = 1'b1; p_vreg1 = 3'd7;
        #1;
        check_val("t5_no_bypass", p_vdata1, 0);
        tick();
        p_VRFWrite = 1'b0;
        check_val("t5_stored", p_vdata1, 32'h12340000);

        // 6: clear_req held through two sweeps
        clear_req = 1'b1;
        busy_hi = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 8) clear_req = 1'b0;
            check_val($sformatf("t6_busy_%0d", k), busy, (k == 4) ? 0 : 1);
            if (busy) busy_hi++;
        end
        tick();
        check_val("t6_busy_end", busy, 0);
        check_val("t6_busy_cycles", busy_hi, 8);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
